linear_stream: RTL and testbench

LINEAR_STREAM -- requirements
Module: linear_stream

---
 rtl/linear_stream_pkg.sv | 31 +++
 rtl/linear_stream_if.sv | 44 ++++
 rtl/linear_post_lane.sv | 62 ++++++
 rtl/linear_stream.sv | 202 ++++++++++++++++++++
 tb/tb_linear_stream.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/linear_stream_pkg.sv
// Shared types and width helpers for the linear_stream fully-connected layer.
package linear_stream_pkg;

  // Controller states of the streaming linear layer.
  typedef enum logic [2:0] {
    ST_LOAD = 3'd0,
    ST_MAC  = 3'd1,
    ST_TAIL = 3'd2,
    ST_POST = 3'd3,
    ST_OUT  = 3'd4
  } state_e;

  // Activation applied after rounding and saturation; code 3 behaves as none.
  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_RELU6 = 2'd2,
    ACT_RSVD  = 2'd3
  } act_mode_e;

  // Address width that never collapses to zero bits for single-entry spaces.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Accumulator wide enough for n full-scale signed products without overflow.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/linear_stream_if.sv
// Bundle of the input stream, weight/bias memory ports and output stream.
interface linear_stream_if #(
  parameter int IN_FEATURES  = 576,
  parameter int OUT_FEATURES = 1280,
  parameter int DATA_WIDTH   = 8,
  parameter int PAR_OUT      = 8
);
  import linear_stream_pkg::*;

  localparam int GROUPS = OUT_FEATURES / PAR_OUT;
  localparam int W_AW   = clog2_min1(GROUPS * IN_FEATURES);
  localparam int B_AW   = clog2_min1(GROUPS);

  logic [1:0]                    act_mode;
  logic [DATA_WIDTH-1:0]         in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic                          w_rd_en;
  logic [W_AW-1:0]               w_addr;
  logic [PAR_OUT*DATA_WIDTH-1:0] w_data;
  logic                          b_rd_en;
  logic [B_AW-1:0]               b_addr;
  logic [PAR_OUT*DATA_WIDTH-1:0] b_data;
  logic [PAR_OUT*DATA_WIDTH-1:0] out_data;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_last;
  logic [B_AW-1:0]               out_group;
  logic                          busy;

  // Layer side: consumes inputs and memory data, produces reads and results.
  modport slave (
    input  act_mode, in_data, in_valid, w_data, b_data, out_ready,
    output in_ready, w_rd_en, w_addr, b_rd_en, b_addr,
           out_data, out_valid, out_last, out_group, busy
  );

  // Environment side: feeds inputs, serves memories, drains results.
  modport master (
    output act_mode, in_data, in_valid, w_data, b_data, out_ready,
    input  in_ready, w_rd_en, w_addr, b_rd_en, b_addr,
           out_data, out_valid, out_last, out_group, busy
  );
endinterface

// File: rtl/linear_post_lane.sv
// One output lane: add bias, round half-up, saturate, then apply activation.
module linear_post_lane
  import linear_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 4,
  parameter int ACC_W      = 20
) (
  input  logic signed [ACC_W-1:0]      acc_i,
  input  logic signed [DATA_WIDTH-1:0] bias_i,
  input  act_mode_e                    mode_i,
  output logic signed [DATA_WIDTH-1:0] res_o
);
  // Two guard bits so accumulator plus scaled bias plus rounding cannot wrap.
  localparam int SW     = ACC_W + 2;
  localparam int MAXV   = (1 << (DATA_WIDTH - 1)) - 1;
  localparam int MINV   = -(1 << (DATA_WIDTH - 1));
  localparam int SIX    = 6 << FRAC_BITS;
  localparam int CAPV   = (SIX < MAXV) ? SIX : MAXV;
  localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

  localparam logic signed [SW-1:0]         RND   = (FRAC_BITS > 0) ? (SW'(1) << RND_SH) : '0;
  localparam logic signed [SW-1:0]         MAX_S = SW'(MAXV);
  localparam logic signed [SW-1:0]         MIN_S = SW'(MINV);
  localparam logic signed [DATA_WIDTH-1:0] MAX_D = DATA_WIDTH'(MAXV);
  localparam logic signed [DATA_WIDTH-1:0] MIN_D = DATA_WIDTH'(MINV);
  localparam logic signed [DATA_WIDTH-1:0] CAP_D = DATA_WIDTH'(CAPV);

  logic signed [SW-1:0]         acc_x;
  logic signed [SW-1:0]         bias_x;
  logic signed [SW-1:0]         sum;
  logic signed [SW-1:0]         rnd;
  logic signed [DATA_WIDTH-1:0] sat;

  // Bias is aligned to the product scale (2*FRAC_BITS fractional bits).
  assign acc_x  = SW'(acc_i);
  assign bias_x = SW'(bias_i) <<< FRAC_BITS;
  assign sum    = acc_x + bias_x + RND;
  assign rnd    = sum >>> FRAC_BITS;

  // Clamp the rounded value into the signed output range.
  always_comb begin
    if (rnd > MAX_S)      sat = MAX_D;
    else if (rnd < MIN_S) sat = MIN_D;
    else                  sat = rnd[DATA_WIDTH-1:0];
  end

  // Activation; reserved code passes the saturated value through.
  always_comb begin
    res_o = sat;
    case (mode_i)
      ACT_RELU: begin
        if (sat[DATA_WIDTH-1]) res_o = '0;
      end
      ACT_RELU6: begin
        if (sat[DATA_WIDTH-1]) res_o = '0;
        else if (sat > CAP_D)  res_o = CAP_D;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/linear_stream.sv
// Streaming fully-connected layer: buffers one input vector, then computes
// PAR_OUT outputs per group from streamed weights and emits one beat per group.
module linear_stream
  import linear_stream_pkg::*;
#(
  parameter int IN_FEATURES  = 576,
  parameter int OUT_FEATURES = 1280,
  parameter int DATA_WIDTH   = 8,
  parameter int FRAC_BITS    = 4,
  parameter int PAR_OUT      = 8
) (
  input  logic          clk,
  input  logic          rst,
  linear_stream_if.slave bus
);
  localparam int GROUPS = OUT_FEATURES / PAR_OUT;
  localparam int W_AW   = clog2_min1(GROUPS * IN_FEATURES);
  localparam int B_AW   = clog2_min1(GROUPS);
  localparam int J_W    = clog2_min1(IN_FEATURES);
  localparam int ACC_W  = acc_width(DATA_WIDTH, IN_FEATURES);
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int VW     = PAR_OUT * DATA_WIDTH;

  localparam logic [J_W-1:0]  J_LAST = J_W'(IN_FEATURES - 1);
  localparam logic [B_AW-1:0] G_LAST = B_AW'(GROUPS - 1);

  state_e           state_q;
  logic [B_AW-1:0]  g_q;
  logic [J_W-1:0]   j_q;
  logic [J_W-1:0]   load_idx_q;
  act_mode_e        act_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             w_rd_en_q;
  logic [W_AW-1:0]  w_addr_q;
  logic             b_rd_en_q;
  logic [B_AW-1:0]  b_addr_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [B_AW-1:0]  out_group_q;
  logic [VW-1:0]    out_data_q;

  logic signed [DATA_WIDTH-1:0] in_buf [IN_FEATURES];
  logic signed [DATA_WIDTH-1:0] x_q;
  logic                         pvalid_q;
  logic                         bvalid_q;
  logic [VW-1:0]                bias_q;
  logic [VW-1:0]                post_flat;
  logic                         acc_clr;

  assign bus.in_ready  = in_ready_q;
  assign bus.busy      = busy_q;
  assign bus.w_rd_en   = w_rd_en_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.b_rd_en   = b_rd_en_q;
  assign bus.b_addr    = b_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_group = out_group_q;
  assign bus.out_data  = out_data_q;

  // First MAC cycle of every group restarts the accumulators.
  assign acc_clr = (state_q == ST_MAC) && (j_q == '0);

  // Controller: sequencing, memory read requests and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_LOAD;
      g_q         <= '0;
      j_q         <= '0;
      load_idx_q  <= '0;
      act_q       <= ACT_NONE;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      w_rd_en_q   <= 1'b0;
      w_addr_q    <= '0;
      b_rd_en_q   <= 1'b0;
      b_addr_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_group_q <= '0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.in_valid) begin
            busy_q <= 1'b1;
            if (load_idx_q == '0) act_q <= act_mode_e'(bus.act_mode);
            if (load_idx_q == J_LAST) begin
              load_idx_q <= '0;
              state_q    <= ST_MAC;
              in_ready_q <= 1'b0;
              g_q        <= '0;
              j_q        <= '0;
              w_rd_en_q  <= 1'b1;
              w_addr_q   <= '0;
              b_rd_en_q  <= 1'b1;
              b_addr_q   <= '0;
            end else begin
              load_idx_q <= load_idx_q + J_W'(1);
            end
          end
        end
        ST_MAC: begin
          b_rd_en_q <= 1'b0;
          if (j_q == J_LAST) begin
            state_q   <= ST_TAIL;
            w_rd_en_q <= 1'b0;
          end else begin
            j_q      <= j_q + J_W'(1);
            w_addr_q <= w_addr_q + W_AW'(1);
          end
        end
        ST_TAIL: state_q <= ST_POST;
        ST_POST: begin
          state_q     <= ST_OUT;
          out_valid_q <= 1'b1;
          out_last_q  <= (g_q == G_LAST);
          out_group_q <= g_q;
          out_data_q  <= post_flat;
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              state_q    <= ST_LOAD;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              g_q        <= '0;
            end else begin
              // Weight address runs on contiguously from the previous group.
              state_q   <= ST_MAC;
              g_q       <= g_q + B_AW'(1);
              j_q       <= '0;
              w_rd_en_q <= 1'b1;
              w_addr_q  <= w_addr_q + W_AW'(1);
              b_rd_en_q <= 1'b1;
              b_addr_q  <= g_q + B_AW'(1);
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  // Input vector RAM: written during LOAD, registered read aligned with w_data.
  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && bus.in_valid) in_buf[load_idx_q] <= bus.in_data;
    x_q <= in_buf[j_q];
  end

  // Track which cycles carry returned weight/bias data and capture the bias.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pvalid_q <= 1'b0;
      bvalid_q <= 1'b0;
      bias_q   <= '0;
    end else begin
      pvalid_q <= w_rd_en_q;
      bvalid_q <= b_rd_en_q;
      if (bvalid_q) bias_q <= bus.b_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PAR_OUT; gi++) begin : g_lane
      logic signed [DATA_WIDTH-1:0] w_lane;
      logic signed [PW-1:0]         prod;
      logic signed [ACC_W-1:0]      acc_q;
      logic signed [ACC_W-1:0]      acc_d;

      assign w_lane = bus.w_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign prod   = PW'(x_q) * PW'(w_lane);

      // Next accumulator: optional clear, then add the product that just returned.
      always_comb begin
        acc_d = acc_clr ? '0 : acc_q;
        if (pvalid_q) acc_d = acc_d + ACC_W'(prod);
      end

      // Accumulator register.
      always_ff @(posedge clk) begin
        if (!rst) acc_q <= '0;
        else      acc_q <= acc_d;
      end

      linear_post_lane #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .ACC_W     (ACC_W)
      ) u_post (
        .acc_i (acc_q),
        .bias_i(bias_q[gi*DATA_WIDTH +: DATA_WIDTH]),
        .mode_i(act_q),
        .res_o (post_flat[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate
endmodule

// File: tb/tb_linear_stream.sv
// Randomized self-checking bench for linear_stream against an arithmetic model.
module tb_linear_stream;
  import linear_stream_pkg::*;

  localparam int IN     = 4;
  localparam int OUT    = 4;
  localparam int PAR    = 2;
  localparam int DW     = 8;
  localparam int FB     = 4;
  localparam int GROUPS = OUT / PAR;
  localparam int MAXV   = (1 << (DW - 1)) - 1;
  localparam int MINV   = -(1 << (DW - 1));

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  int x_tb [IN];
  int w_tb [GROUPS*IN][PAR];
  int b_tb [GROUPS][PAR];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  linear_stream_if #(.IN_FEATURES(IN), .OUT_FEATURES(OUT), .DATA_WIDTH(DW), .PAR_OUT(PAR)) bus ();

  linear_stream #(
    .IN_FEATURES(IN), .OUT_FEATURES(OUT), .DATA_WIDTH(DW), .FRAC_BITS(FB), .PAR_OUT(PAR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Weight and bias memories answer one cycle after each read request.
  always @(posedge clk) begin
    if (bus.w_rd_en)
      for (int l = 0; l < PAR; l++) bus.w_data[l*DW +: DW] <= DW'(w_tb[int'(bus.w_addr)][l]);
    if (bus.b_rd_en)
      for (int l = 0; l < PAR; l++) bus.b_data[l*DW +: DW] <= DW'(b_tb[int'(bus.b_addr)][l]);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected output of one lane straight from the layer's arithmetic definition.
  function automatic longint model_lane(input int g, input int lane, input int mode);
    longint acc = 0;
    longint r;
    longint cap = ((6 << FB) < MAXV) ? (6 << FB) : MAXV;
    for (int j = 0; j < IN; j++) acc += longint'(x_tb[j]) * longint'(w_tb[g*IN + j][lane]);
    r = acc + longint'(b_tb[g][lane]) * longint'(1 << FB);
    r = (r + longint'(1 << (FB - 1))) >>> FB;
    if (r > MAXV) r = MAXV;
    if (r < MINV) r = MINV;
    if (mode == 1 && r < 0) r = 0;
    if (mode == 2) begin
      if (r < 0) r = 0;
      if (r > cap) r = cap;
    end
    return r;
  endfunction

  task automatic fill_const(input int xv, input int wv, input int bv);
    for (int j = 0; j < IN; j++) x_tb[j] = xv;
    for (int a = 0; a < GROUPS*IN; a++) for (int l = 0; l < PAR; l++) w_tb[a][l] = wv;
    for (int g = 0; g < GROUPS; g++) for (int l = 0; l < PAR; l++) b_tb[g][l] = bv;
  endtask

  task automatic fill_random(input int amp);
    for (int j = 0; j < IN; j++) x_tb[j] = int'($urandom_range(0, 2*amp)) - amp;
    for (int a = 0; a < GROUPS*IN; a++)
      for (int l = 0; l < PAR; l++) w_tb[a][l] = int'($urandom_range(0, 2*amp)) - amp;
    for (int g = 0; g < GROUPS; g++)
      for (int l = 0; l < PAR; l++) b_tb[g][l] = int'($urandom_range(0, 2*amp)) - amp;
  endtask

  // Rounding / activation corner vector: raw sums 24, -24, -320, 1920.
  task automatic fill_corners();
    fill_const(0, 0, 0);
    x_tb[0] = 4; x_tb[1] = 2; x_tb[2] = 16;
    w_tb[0][0] = 3;  w_tb[1][0] = 6;
    w_tb[0][1] = -3; w_tb[1][1] = -6;
    w_tb[IN + 2][0] = -20;
    w_tb[IN + 2][1] = 120;
  endtask

  task automatic load_frame(input int mode, output longint entry);
    for (int i = 0; i < IN; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      @(negedge clk);
      check("in_ready_load", longint'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(x_tb[i]);
      bus.act_mode = (i == 0) ? 2'(mode) : 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      if (i == 0) check("busy_after_first", longint'(bus.busy), 1);
    end
    entry = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain_frame(input int mode, input longint entry_in, input int stall_fix);
    longint entry = entry_in;
    // Junk beats offered during compute must never be consumed.
    bus.in_valid = 1'b1;
    bus.in_data  = DW'($urandom);
    for (int g = 0; g < GROUPS; g++) begin
      int             jcnt = 0;
      bit             got = 1'b0;
      int             stall;
      logic [PAR*DW-1:0] held;
      for (int t = 0; t < 100 && !got; t++) begin
        @(negedge clk);
        if (bus.out_valid) got = 1'b1;
        else begin
          check("in_ready_frame", longint'(bus.in_ready), 0);
          check("busy_frame", longint'(bus.busy), 1);
          if (bus.w_rd_en) begin
            check("w_addr", longint'(bus.w_addr), g*IN + jcnt);
            jcnt++;
          end
          if (bus.b_rd_en) begin
            check("b_addr", longint'(bus.b_addr), g);
            check("b_rd_cycle", cyc, entry);
          end
        end
      end
      bus.in_valid = 1'b0;
      check("out_valid_seen", longint'(got), 1);
      check("w_read_count", jcnt, IN);
      check("latency", cyc - entry, IN + 2);
      check("out_group", longint'(bus.out_group), g);
      check("out_last", longint'(bus.out_last), (g == GROUPS - 1) ? 1 : 0);
      for (int l = 0; l < PAR; l++)
        check($sformatf("g%0d_lane%0d_m%0d", g, l, mode),
              longint'($signed(bus.out_data[l*DW +: DW])), model_lane(g, l, mode));
      held  = bus.out_data;
      stall = (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, 3));
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check("hold_valid", longint'(bus.out_valid), 1);
        check("hold_data", longint'(bus.out_data), longint'(held));
        check("hold_group", longint'(bus.out_group), g);
        check("hold_no_wread", longint'(bus.w_rd_en), 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      entry = cyc;
    end
    @(negedge clk);
    check("idle_in_ready", longint'(bus.in_ready), 1);
    check("idle_busy", longint'(bus.busy), 0);
    check("idle_out_valid", longint'(bus.out_valid), 0);
  endtask

  task automatic run_frame(input int mode, input int stall_fix);
    longint entry;
    load_frame(mode, entry);
    drain_frame(mode, entry, stall_fix);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    longint entry;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.act_mode  = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_last", longint'(bus.out_last), 0);
    check("rst_out_group", longint'(bus.out_group), 0);
    check("rst_w_rd_en", longint'(bus.w_rd_en), 0);
    check("rst_b_rd_en", longint'(bus.b_rd_en), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_in_ready", longint'(bus.in_ready), 1);

    // All-16 vector, five stall cycles on every output beat.
    fill_const(16, 16, 0);
    run_frame(0, 5);
    // Saturation at both ends.
    fill_const(127, 127, 0);
    run_frame(0, -1);
    fill_const(127, -128, 0);
    run_frame(0, -1);
    // Rounding and activation corners under each mode.
    fill_corners();
    for (int m = 0; m < 4; m++) run_frame(m, -1);

    // Reset in the middle of MAC abandons the frame.
    fill_random(30);
    load_frame(0, entry);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", longint'(bus.out_valid), 0);
    check("midrst_in_ready", longint'(bus.in_ready), 1);
    check("midrst_busy", longint'(bus.busy), 0);
    for (int t = 0; t < IN + 6; t++) begin
      @(negedge clk);
      check("midrst_no_output", longint'(bus.out_valid), 0);
      check("midrst_no_wread", longint'(bus.w_rd_en), 0);
    end

    // Randomized frames, mixed magnitudes and modes.
    for (int f = 0; f < 12; f++) begin
      fill_random(($urandom_range(0, 1) == 1) ? 127 : 24);
      run_frame(int'($urandom_range(0, 3)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
